// File: rtl/riscv_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu_pkg
// Description : Shared widths, ALU opcodes and divider types for the core.
// Revision    : 1.0 - divider FSM states and special-case constants added
// ============================================================================
package riscv_cpu_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ALU_OP_WIDTH = 5;

    // bit0 = signed, bit1 = remainder within the divide group 5'b111xx
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_XOR  = 5'b00010,
        ALU_OR   = 5'b00011,
        ALU_AND  = 5'b00100,
        ALU_SLL  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_SLT  = 5'b01000,
        ALU_SLTU = 5'b01001,
        ALU_DIVU = 5'b11100,
        ALU_DIV  = 5'b11101,
        ALU_REMU = 5'b11110,
        ALU_REM  = 5'b11111
    } alu_opcode_e;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_DIVIDE = 2'd1,
        DIV_SIGN   = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_e;

    localparam int unsigned DIV_ITERATIONS   = XLEN;
    localparam int unsigned DIV_CNT_WIDTH    = $clog2(DIV_ITERATIONS);
    localparam logic [31:0] DIV0_QUOTIENT    = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_QUOTIENT = 32'h8000_0000;

    function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
        return (op | 5'b00011) == 5'b11111;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_cpu_div_step.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu_div_step
// Description : One combinational radix-2 restoring division step.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_cpu_div_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH:0]   rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH+1:0] w_shifted;
    logic [DATA_WIDTH+1:0] w_diff;
    logic                  w_borrow;

    // The partial remainder stays below the divisor, so its top bit is zero
    // and a negative trial difference always shows up in the extra MSB.
    assign w_shifted = {rem_i, quo_i[DATA_WIDTH-1]};
    assign w_diff    = w_shifted - {2'b00, divisor_i};
    assign w_borrow  = w_diff[DATA_WIDTH+1];

    assign rem_o = w_borrow ? w_shifted[DATA_WIDTH:0] : w_diff[DATA_WIDTH:0];
    assign quo_o = {quo_i[DATA_WIDTH-2:0], ~w_borrow};

endmodule
`default_nettype wire

// File: rtl/riscv_cpu_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu_div_ctrl
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU with FSM.
//               Optional macro RISCV_CPU_DIV_FAST_EN short-cuts div0/ovf/a==0.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_cpu_div_ctrl
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  alu_opcode_e           operator_i,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    input  logic                  kill_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o
);

    localparam logic [DATA_WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] C_MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  C_CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH:0]   rem_q;
    logic [DATA_WIDTH-1:0] quo_q, divisor_q, result_q;
    logic                  neg_quo_q, neg_rem_q, rem_sel_q, div0_q, ovf_q;

    logic [ALU_OP_WIDTH-1:0] w_op;
    logic                    w_signed, w_rem, w_a_neg, w_b_neg;
    logic                    w_div0, w_ovf, w_accept;
    logic [DATA_WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [DATA_WIDTH:0]     w_step_rem;
    logic [DATA_WIDTH-1:0]   w_step_quo;
    logic [DATA_WIDTH-1:0]   w_quo_fin, w_rem_fin, w_final;
    logic                    w_fast;
    logic [DATA_WIDTH-1:0]   w_fast_result;

    assign w_op     = operator_i;
    assign w_signed = w_op[0];
    assign w_rem    = w_op[1];
    assign w_a_neg  = w_signed & op_a_i[DATA_WIDTH-1];
    assign w_b_neg  = w_signed & op_b_i[DATA_WIDTH-1];
    // Negating the most negative value wraps back to itself, which is the
    // correct unsigned magnitude.
    assign w_abs_a  = w_a_neg ? -op_a_i : op_a_i;
    assign w_abs_b  = w_b_neg ? -op_b_i : op_b_i;
    assign w_div0   = (op_b_i == '0);
    assign w_ovf    = w_signed && (op_a_i == C_MIN_NEG) && (op_b_i == C_ALL_ONES);
    assign w_accept = valid_i && (state_q == DIV_IDLE) && !kill_i && is_div_op(w_op);

`ifdef RISCV_CPU_DIV_FAST_EN
    always_comb begin
        w_fast        = w_div0 | w_ovf | (op_a_i == '0);
        w_fast_result = '0;
        if (w_div0) begin
            w_fast_result = w_rem ? op_a_i : C_ALL_ONES;
        end else if (w_ovf) begin
            w_fast_result = w_rem ? '0 : C_MIN_NEG;
        end
    end
`else
    assign w_fast        = 1'b0;
    assign w_fast_result = '0;
`endif

    riscv_cpu_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (w_step_rem),
        .quo_o     (w_step_quo)
    );

    // With a zero divisor the iterations leave |a| in the remainder, so the
    // sign fix-up alone already yields a; only the quotient needs overriding.
    always_comb begin
        w_quo_fin = neg_quo_q ? -quo_q : quo_q;
        w_rem_fin = neg_rem_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
        if (div0_q) begin
            w_quo_fin = C_ALL_ONES;
        end
        if (ovf_q) begin
            w_quo_fin = C_MIN_NEG;
            w_rem_fin = '0;
        end
        w_final = rem_sel_q ? w_rem_fin : w_quo_fin;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE:   if (w_accept) state_d = w_fast ? DIV_DONE : DIV_DIVIDE;
            DIV_DIVIDE: if (cnt_q == C_CNT_LAST) state_d = DIV_SIGN;
            DIV_SIGN:   state_d = DIV_DONE;
            DIV_DONE:   if (ready_i) state_d = DIV_IDLE;
            default:    state_d = DIV_IDLE;
        endcase
        if (kill_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (w_accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= w_abs_a;
            divisor_q <= w_abs_b;
            neg_quo_q <= w_a_neg ^ w_b_neg;
            neg_rem_q <= w_a_neg;
            rem_sel_q <= w_rem;
            div0_q    <= w_div0;
            ovf_q     <= w_ovf;
            if (w_fast) begin
                result_q <= w_fast_result;
            end
        end else if (state_q == DIV_DIVIDE) begin
            rem_q <= w_step_rem;
            quo_q <= w_step_quo;
            cnt_q <= (cnt_q == C_CNT_LAST) ? '0 : cnt_q + CNT_WIDTH'(1);
        end else if ((state_q == DIV_SIGN) && !kill_i) begin
            result_q <= w_final;
        end
    end

    assign ready_o  = (state_q == DIV_IDLE);
    assign valid_o  = (state_q == DIV_DONE);
    assign busy_o   = (state_q != DIV_IDLE);
    assign result_o = result_q;

endmodule
`default_nettype wire
